iob_csrs_txn_checker: RTL

Parametrised, self-checking IOb native bus master that drives a CSR slave such as the iob_csrs_demo core.
- Accepts a stream of write/read commands through a small command FIFO and issues them one at a time on the IOb bus.
- Compares each read response against an expected value under a bit mask, and keeps error, transaction and timeout statistics.
- Sits between a simulation or bring-up sequencer and any `*_csrs` block, replacing open-coded pass/fail checks in benches.

---
 rtl/iob_csrs_txn_checker.sv | 250 +++++++++++++++++++++++++
 1 files changed

// File: rtl/iob_csrs_txn_checker.sv
// iob_csrs_txn_checker: IOb master that replays queued write/read commands against a CSR slave
// Latency: a command accepted at edge k raises iob_valid_o from edge k+1, with one idle bubble between transactions
// Backpressure: cmd_ready_o is low while the command FIFO is full and no pop happens in the same cycle
//
// Ports:
//   clk_i, rst_i               clock, synchronous active-high reset
//   cmd_*                      command stream (valid/ready) into the FIFO
//   iob_*                      IOb native master request/response
//   clear_i                    synchronous clear of statistics and sticky flags
//   busy_o, txn_cnt_o, err_cnt_o, mismatch_o, timeout_o, last_err_addr_o  status

// Generic FIFO, registered storage, head visible combinationally on data_o.
// Latency: a pushed entry is visible on data_o one cycle after the push edge.
// Backpressure: caller must only push when !full_o or when popping in the same cycle.
module iob_csrs_txn_checker_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] data_i,
  output logic [W-1:0] data_o,
  output logic         full_o,
  output logic         empty_o
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   cnt_q;

  // Storage carries no reset; only pointers and occupancy define validity.
  always_ff @(posedge clk_i) begin
    if (push_i) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push_i) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop_i) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({push_i, pop_i})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
endmodule

module iob_csrs_txn_checker #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                cmd_valid_i,
  output logic                cmd_ready_o,
  input  logic                cmd_write_i,
  input  logic [ADDR_W-1:0]   cmd_addr_i,
  input  logic [DATA_W-1:0]   cmd_data_i,
  input  logic [DATA_W-1:0]   cmd_mask_i,
  input  logic [DATA_W/8-1:0] cmd_wstrb_i,
  output logic                iob_valid_o,
  output logic [ADDR_W-1:0]   iob_addr_o,
  output logic [DATA_W-1:0]   iob_wdata_o,
  output logic [DATA_W/8-1:0] iob_wstrb_o,
  input  logic                iob_ready_i,
  input  logic                iob_rvalid_i,
  input  logic [DATA_W-1:0]   iob_rdata_i,
  input  logic                clear_i,
  output logic                busy_o,
  output logic [CNT_W-1:0]    txn_cnt_o,
  output logic [CNT_W-1:0]    err_cnt_o,
  output logic                mismatch_o,
  output logic                timeout_o,
  output logic [ADDR_W-1:0]   last_err_addr_o
);
  typedef struct packed {
    logic                write;
    logic [ADDR_W-1:0]   addr;
    logic [DATA_W-1:0]   data;
    logic [DATA_W-1:0]   mask;
    logic [DATA_W/8-1:0] wstrb;
  } cmd_t;

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT} state_t;

  // Timer value on the last cycle a transaction may still wait before it is dropped.
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  state_t            state_q, state_d;
  cmd_t              req_q, req_d;
  logic [15:0]       timer_q, timer_d;
  logic [CNT_W-1:0]  txn_cnt_q, txn_cnt_d;
  logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;
  logic              mismatch_q;
  logic              timeout_q, timeout_d;
  logic [ADDR_W-1:0] last_err_addr_q, last_err_addr_d;

  cmd_t fifo_in, fifo_head;
  logic fifo_full, fifo_empty;
  logic push, pop;
  logic txn_inc, mismatch_evt, timeout_evt, err_evt;

  // Clear and increment in the same cycle leave the counter at 1.
  function automatic logic [CNT_W-1:0] cnt_upd(input logic [CNT_W-1:0] c,
                                               input logic inc, input logic clr);
    if (clr) return inc ? CNT_W'(1) : '0;
    if (inc && (c != '1)) return c + 1'b1;
    return c;
  endfunction

  // Pop depends only on registered state, so cmd_ready_o has no path from cmd_valid_i.
  assign pop         = (state_q == ST_IDLE) && !fifo_empty;
  assign cmd_ready_o = !fifo_full || pop;
  assign push        = cmd_valid_i && cmd_ready_o;

  always_comb begin
    fifo_in       = '0;
    fifo_in.write = cmd_write_i;
    fifo_in.addr  = cmd_addr_i;
    fifo_in.data  = cmd_data_i;
    fifo_in.mask  = cmd_mask_i;
    fifo_in.wstrb = cmd_write_i ? cmd_wstrb_i : '0;
  end

  iob_csrs_txn_checker_fifo #(
    .W     ($bits(cmd_t)),
    .DEPTH (DEPTH)
  ) u_cmd_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  (fifo_in),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    state_d      = state_q;
    req_d        = req_q;
    timer_d      = timer_q;
    txn_inc      = 1'b0;
    mismatch_evt = 1'b0;
    timeout_evt  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pop) begin
          req_d   = fifo_head;
          timer_d = '0;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (iob_ready_i) begin
          if (req_q.write) begin
            txn_inc = 1'b1;
            state_d = ST_IDLE;
          end else begin
            timer_d = '0;
            state_d = ST_WAIT;
          end
        end else if (timer_q == TMO_LAST) begin
          timeout_evt = 1'b1;
          state_d     = ST_IDLE;
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end
      ST_WAIT: begin
        if (iob_rvalid_i) begin
          txn_inc      = 1'b1;
          mismatch_evt = |((iob_rdata_i ^ req_q.data) & req_q.mask);
          state_d      = ST_IDLE;
        end else if (timer_q == TMO_LAST) begin
          timeout_evt = 1'b1;
          state_d     = ST_IDLE;
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Mismatch and timeout are mutually exclusive, so the error counter moves by at most one.
  assign err_evt = mismatch_evt || timeout_evt;

  always_comb begin
    txn_cnt_d       = cnt_upd(txn_cnt_q, txn_inc, clear_i);
    err_cnt_d       = cnt_upd(err_cnt_q, err_evt, clear_i);
    timeout_d       = timeout_evt ? 1'b1 : (clear_i ? 1'b0 : timeout_q);
    last_err_addr_d = err_evt ? req_q.addr : (clear_i ? '0 : last_err_addr_q);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q         <= ST_IDLE;
      req_q           <= '0;
      timer_q         <= '0;
      txn_cnt_q       <= '0;
      err_cnt_q       <= '0;
      mismatch_q      <= 1'b0;
      timeout_q       <= 1'b0;
      last_err_addr_q <= '0;
    end else begin
      state_q         <= state_d;
      req_q           <= req_d;
      timer_q         <= timer_d;
      txn_cnt_q       <= txn_cnt_d;
      err_cnt_q       <= err_cnt_d;
      mismatch_q      <= mismatch_evt;
      timeout_q       <= timeout_d;
      last_err_addr_q <= last_err_addr_d;
    end
  end

  assign iob_valid_o     = (state_q == ST_REQ);
  assign iob_addr_o      = req_q.addr;
  assign iob_wdata_o     = req_q.data;
  assign iob_wstrb_o     = req_q.wstrb;
  assign busy_o          = !fifo_empty || (state_q != ST_IDLE);
  assign txn_cnt_o       = txn_cnt_q;
  assign err_cnt_o       = err_cnt_q;
  assign mismatch_o      = mismatch_q;
  assign timeout_o       = timeout_q;
  assign last_err_addr_o = last_err_addr_q;
endmodule
